regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//  Write-back scheduler and scoreboard in front of the 32x32 register file's single write port.
//  - Arbitrates two write-back sources (ALU, load unit) round-robin onto the port.
//  - Tracks in-flight destination registers so issue stalls on RAW/WAW hazards.
//  - Drives Regwrite/rd/WD3 of the register file from registered outputs.
// PARAMETERS
//  XLEN    32  data width of a register
//  NREG    32  number of architectural registers (x0 hardwired zero)
//  AW      5   register index width, $clog2(NREG)
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  rst          in   1     asynchronous, active-low reset
//  flush        in   1     sync clear of all pending bits (pipeline flush)
//  iss_valid    in   1     decode presents an instruction
//  iss_rs1      in   AW    source register 1 of issuing instruction
//  iss_rs2      in   AW    source register 2 of issuing instruction
//  iss_rd       in   AW    destination of issuing instruction
//  iss_has_rd   in   1     instruction writes iss_rd
//  iss_stall    out  1     hazard: issue must hold this cycle
//  alu_valid    in   1     ALU write-back request
//  alu_rd       in   AW    ALU destination
//  alu_data     in   XLEN  ALU result
//  alu_ready    out  1     ALU request granted this cycle
//  mem_valid    in   1     load write-back request
//  mem_rd       in   AW    load destination
//  mem_data     in   XLEN  load data
//  mem_ready    out  1     load request granted this cycle
//  rf_we        out  1     to register file Regwrite
//  rf_rd        out  AW    to register file rd
//  rf_wd        out  XLEN  to register file WD3
//  pend_cnt     out  AW+1  number of pending destination registers
//  err_unexp    out  1     sticky: write-back to a non-pending register
// BEHAVIOUR
//  Reset (rst=0, async): pend[]=0, rr_last=MEM (ALU wins first tie), rf_we=0, rf_rd=0,
//   rf_wd=0, pend_cnt=0, err_unexp=0. Reset mid-operation discards everything in flight.
//  Scoreboard:
//  - pend[0] always 0.
//  - iss_stall = iss_valid & (pend[iss_rs1] | pend[iss_rs2] | (iss_has_rd & pend[iss_rd])).
//    Combinational on registered pend only; no bypass of same-cycle grants.
//  - Set: iss_valid & ~iss_stall & iss_has_rd & iss_rd!=0 -> pend[iss_rd]<=1 at the edge.
//  - Clear: grant of writer w -> pend[w_rd]<=0 at the same edge. Set and clear of the same
//    index in one cycle: set wins.
//  - flush=1: all pend<=0; a set in the same cycle is ignored; grants still proceed.
//  - pend_cnt = popcount(pend), registered alongside pend.
//  Arbitration (one grant per cycle, ready combinational):
//  - One valid requester -> grant it.
//  - Both valid -> grant the one not equal to rr_last; rr_last <= granted source.
//  - No grant -> rr_last unchanged.
//  - Requester holds valid/rd/data stable until its ready=1 (valid/ready handshake).
//  Write port, 1-cycle latency, grant in cycle N -> rf_* valid in cycle N+1:
//  - rf_we <= grant & (w_rd!=0); rf_rd <= w_rd; rf_wd <= w_data.
//  - No grant -> rf_we<=0, rf_rd/rf_wd hold.
//  - Writes to x0 are granted (ready=1) but rf_we stays 0.
//  - Error: grant with w_rd!=0 & pend[w_rd]==0 & ~flush -> err_unexp<=1 (sticky until reset).
//    Write is still performed.
// STRUCTURE
//  - Shared package regfile_pkg: XLEN, NREG, AW, REG_X0 ('0), source enum {SRC_ALU, SRC_MEM}.
//  - One sub-module rr_arb2 (2-way round-robin: req[1:0] -> gnt[1:0], internal rr_last flop).
//  - Scoreboard, write register and popcount inline in this module.
// TESTING
//  1. Reset: hold rst=0 with inputs toggling -> all outputs 0; release, no requests -> rf_we=0.
//  2. Issue rd=5 (rs1=1,rs2=2) -> pend_cnt=1. Next issue rs1=5 -> iss_stall=1.
//     ALU writes rd=5 data=0xDEADBEEF -> next cycle rf_we=1,rf_rd=5,rf_wd=0xDEADBEEF;
//     stall drops the cycle after the grant.
//  3. Tie: ALU rd=3 and MEM rd=4 both valid from reset -> ALU granted first, MEM next;
//     repeat tie -> ALU, MEM alternate.
//  4. x0: MEM write rd=0 -> mem_ready=1, rf_we=0, pend_cnt unchanged, err_unexp=0.
//  5. Flush: pend rd=7,8 set, flush with issue rd=9 same cycle -> pend_cnt=0, pend[9]=0.
//     Later ALU write rd=7 -> err_unexp=1.
//  6. Async reset asserted mid-grant (ALU valid) -> rf_we=0 immediately, pend_cnt=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, source enum and popcount helper for the write-back scheduler
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    localparam logic [AW-1:0] REG_X0 = '0;

    // Bit positions of the two write-back sources in the arbiter request/grant vectors
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - issue, write-back and register-file signals of the scheduler
interface regfile_wb_scheduler_if;
    import regfile_pkg::*;

    logic            flush;
    logic            iss_valid;
    logic [AW-1:0]   iss_rs1;
    logic [AW-1:0]   iss_rs2;
    logic [AW-1:0]   iss_rd;
    logic            iss_has_rd;
    logic            iss_stall;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic [AW:0]     pend_cnt;
    logic            err_unexp;

    modport slave (
        input  flush, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_has_rd,
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output iss_stall, alu_ready, mem_ready,
        output rf_we, rf_rd, rf_wd, pend_cnt, err_unexp
    );

    modport master (
        output flush, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_has_rd,
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  iss_stall, alu_ready, mem_ready,
        input  rf_we, rf_rd, rf_wd, pend_cnt, err_unexp
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with combinational grant
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    src_e rr_last_q;
    src_e rr_last_d;

    // Grant a lone requester directly; on a tie favour the source not granted last
    always_comb begin
        gnt       = 2'b00;
        rr_last_d = rr_last_q;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (rr_last_q == SRC_MEM) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (gnt[SRC_ALU]) begin
            rr_last_d = SRC_ALU;
        end else if (gnt[SRC_MEM]) begin
            rr_last_d = SRC_MEM;
        end
    end

    // Remember the last granted source; reset value lets the ALU win the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q <= SRC_MEM;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - write-back arbitration, hazard scoreboard and register-file write port
module regfile_wb_scheduler
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_scheduler_if.slave bus
);

    logic [NREG-1:0] pend_q,     pend_d;
    logic [AW:0]     pend_cnt_q, pend_cnt_d;
    logic            rf_we_q,    rf_we_d;
    logic [AW-1:0]   rf_rd_q,    rf_rd_d;
    logic [XLEN-1:0] rf_wd_q,    rf_wd_d;
    logic            err_q,      err_d;

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            any_gnt;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_data;
    logic            iss_set;

    // Requests are masked during reset so no ready is raised while the block is held
    assign req = {bus.mem_valid, bus.alu_valid} & {2{rst}};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign any_gnt       = |gnt;
    assign bus.alu_ready = gnt[SRC_ALU];
    assign bus.mem_ready = gnt[SRC_MEM];

    // Hazard check looks only at registered pend; a grant this cycle does not unblock issue yet
    assign bus.iss_stall = bus.iss_valid &
                           (pend_q[bus.iss_rs1] | pend_q[bus.iss_rs2] |
                            (bus.iss_has_rd & pend_q[bus.iss_rd]));

    assign iss_set = bus.iss_valid & ~bus.iss_stall & bus.iss_has_rd & (bus.iss_rd != REG_X0);

    // Select destination and data of the granted writer
    always_comb begin
        w_rd   = bus.alu_rd;
        w_data = bus.alu_data;
        if (gnt[SRC_MEM]) begin
            w_rd   = bus.mem_rd;
            w_data = bus.mem_data;
        end
    end

    // Next scoreboard state: flush beats everything, otherwise a new issue beats a completing write
    always_comb begin
        pend_d = pend_q;
        if (bus.flush) begin
            pend_d = '0;
        end else begin
            if (any_gnt) begin
                pend_d[w_rd] = 1'b0;
            end
            if (iss_set) begin
                pend_d[bus.iss_rd] = 1'b1;
            end
        end
        pend_d[REG_X0] = 1'b0;
        pend_cnt_d     = popcount(pend_d);
    end

    // Next write-port state; rd/wd hold when idle and x0 writes are swallowed
    always_comb begin
        rf_we_d = 1'b0;
        rf_rd_d = rf_rd_q;
        rf_wd_d = rf_wd_q;
        err_d   = err_q;
        if (any_gnt) begin
            rf_we_d = (w_rd != REG_X0);
            rf_rd_d = w_rd;
            rf_wd_d = w_data;
            if ((w_rd != REG_X0) && !pend_q[w_rd] && !bus.flush) begin
                err_d = 1'b1;
            end
        end
    end

    // State registers for the scoreboard, its population count and the write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q     <= '0;
            pend_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wd_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wd_q    <= rf_wd_d;
            err_q      <= err_d;
        end
    end

    assign bus.rf_we     = rf_we_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.pend_cnt  = pend_cnt_q;
    assign bus.err_unexp = err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - self-checking bench for the write-back scheduler
module tb_regfile_wb_scheduler;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if ifc ();

    regfile_wb_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural view of pending registers and the write port
    bit              m_pend [NREG];
    bit              m_last_mem = 1'b1;
    logic            m_we       = 1'b0;
    logic [AW-1:0]   m_rd       = '0;
    logic [XLEN-1:0] m_wd       = '0;
    bit              m_err      = 1'b0;

    function automatic bit m_gnt_alu();
        return rst && ifc.alu_valid && (!ifc.mem_valid || m_last_mem);
    endfunction

    function automatic bit m_gnt_mem();
        return rst && ifc.mem_valid && (!ifc.alu_valid || !m_last_mem);
    endfunction

    function automatic bit m_stall();
        return ifc.iss_valid && (m_pend[ifc.iss_rs1] || m_pend[ifc.iss_rs2] ||
                                 (ifc.iss_has_rd && m_pend[ifc.iss_rd]));
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        bit              ga, gm, st;
        logic [AW-1:0]   wrd;
        logic [XLEN-1:0] wd;
        if (!rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_last_mem = 1'b1;
            m_we = 1'b0; m_rd = '0; m_wd = '0; m_err = 1'b0;
        end else begin
            ga  = m_gnt_alu();
            gm  = m_gnt_mem();
            st  = m_stall();
            wrd = gm ? ifc.mem_rd : ifc.alu_rd;
            wd  = gm ? ifc.mem_data : ifc.alu_data;
            if (ga || gm) begin
                if (wrd != 0 && !m_pend[wrd] && !ifc.flush) m_err = 1'b1;
                m_we = (wrd != 0);
                m_rd = wrd;
                m_wd = wd;
                m_last_mem = gm;
            end else begin
                m_we = 1'b0;
            end
            if (ifc.flush) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
            end else begin
                if (ga || gm) m_pend[wrd] = 1'b0;
                if (ifc.iss_valid && !st && ifc.iss_has_rd && ifc.iss_rd != 0) m_pend[ifc.iss_rd] = 1'b1;
            end
            m_pend[0] = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("rf_we",     64'(ifc.rf_we),     64'(m_we));
        chk("rf_rd",     64'(ifc.rf_rd),     64'(m_rd));
        chk("rf_wd",     64'(ifc.rf_wd),     64'(m_wd));
        chk("pend_cnt",  64'(ifc.pend_cnt),  64'(m_count()));
        chk("err_unexp", 64'(ifc.err_unexp), 64'(m_err));
        chk("iss_stall", 64'(ifc.iss_stall), 64'(m_stall()));
        chk("alu_ready", 64'(ifc.alu_ready), 64'(m_gnt_alu()));
        chk("mem_ready", 64'(ifc.mem_ready), 64'(m_gnt_mem()));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc.flush = 0; ifc.iss_valid = 0; ifc.iss_rs1 = 0; ifc.iss_rs2 = 0;
        ifc.iss_rd = 0; ifc.iss_has_rd = 0;
        ifc.alu_valid = 0; ifc.alu_rd = 0; ifc.alu_data = 0;
        ifc.mem_valid = 0; ifc.mem_rd = 0; ifc.mem_data = 0;
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic has_rd);
        ifc.iss_valid = 1; ifc.iss_rs1 = rs1; ifc.iss_rs2 = rs2;
        ifc.iss_rd = rd; ifc.iss_has_rd = has_rd;
    endtask

    task automatic do_reset();
        cyc();
        rst = 0;
        idle();
        cyc();
        cyc();
        rst = 1;
    endtask

    initial begin
        rst = 0;
        idle();

        // 1. Reset held with toggling inputs
        for (int k = 0; k < 4; k++) begin
            cyc();
            ifc.iss_valid = 1'($urandom); ifc.iss_has_rd = 1'($urandom);
            ifc.iss_rs1 = AW'($urandom); ifc.iss_rs2 = AW'($urandom); ifc.iss_rd = AW'($urandom);
            ifc.alu_valid = 1'($urandom); ifc.alu_rd = AW'($urandom); ifc.alu_data = $urandom;
            ifc.mem_valid = 1'($urandom); ifc.mem_rd = AW'($urandom); ifc.mem_data = $urandom;
            #1;
            chk("rst_we",  64'(ifc.rf_we), 0);
            chk("rst_cnt", 64'(ifc.pend_cnt), 0);
            chk("rst_rdy", 64'({ifc.alu_ready, ifc.mem_ready}), 0);
            chk("rst_wd",  64'(ifc.rf_wd), 0);
        end
        cyc();
        idle();
        rst = 1;
        cyc();
        chk("idle_we", 64'(ifc.rf_we), 0);

        // 2. RAW hazard on x5 resolved by an ALU write-back
        issue(1, 2, 5, 1);
        #1 chk("t2_nostall", 64'(ifc.iss_stall), 0);
        cyc();
        issue(5, 0, 6, 1);
        ifc.alu_valid = 1; ifc.alu_rd = 5; ifc.alu_data = 32'hDEADBEEF;
        #1;
        chk("t2_cnt1",  64'(ifc.pend_cnt), 1);
        chk("t2_stall", 64'(ifc.iss_stall), 1);
        chk("t2_ardy",  64'(ifc.alu_ready), 1);
        cyc();
        ifc.alu_valid = 0;
        #1;
        chk("t2_we", 64'(ifc.rf_we), 1);
        chk("t2_rd", 64'(ifc.rf_rd), 5);
        chk("t2_wd", 64'(ifc.rf_wd), 64'h0000_0000_DEAD_BEEF);
        chk("t2_stall_drop", 64'(ifc.iss_stall), 0);
        cyc();
        ifc.iss_valid = 0;
        ifc.alu_valid = 1; ifc.alu_rd = 6; ifc.alu_data = 32'h66;
        #1 chk("t2_cnt6", 64'(ifc.pend_cnt), 1);
        cyc();
        ifc.alu_valid = 0;
        cyc();
        chk("t2_cnt0", 64'(ifc.pend_cnt), 0);

        // 3. Round-robin ties from reset
        do_reset();
        cyc();
        issue(0, 0, 3, 1);  cyc();
        issue(0, 0, 4, 1);  cyc();
        issue(0, 0, 10, 1); cyc();
        issue(0, 0, 11, 1); cyc();
        ifc.iss_valid = 0;
        ifc.alu_valid = 1; ifc.alu_rd = 3; ifc.alu_data = 32'hA3;
        ifc.mem_valid = 1; ifc.mem_rd = 4; ifc.mem_data = 32'hB4;
        #1;
        chk("t3_cnt4", 64'(ifc.pend_cnt), 4);
        chk("t3_tie1", 64'({ifc.alu_ready, ifc.mem_ready}), 2'b10);
        cyc();
        ifc.alu_rd = 10; ifc.alu_data = 32'hA10;
        #1;
        chk("t3_rd3",  64'(ifc.rf_rd), 3);
        chk("t3_tie2", 64'({ifc.alu_ready, ifc.mem_ready}), 2'b01);
        cyc();
        ifc.mem_rd = 11; ifc.mem_data = 32'hB11;
        #1;
        chk("t3_wd4",  64'(ifc.rf_wd), 32'hB4);
        chk("t3_tie3", 64'({ifc.alu_ready, ifc.mem_ready}), 2'b10);
        cyc();
        ifc.alu_valid = 0;
        #1;
        chk("t3_rd10", 64'(ifc.rf_rd), 10);
        chk("t3_solo", 64'({ifc.alu_ready, ifc.mem_ready}), 2'b01);
        cyc();
        ifc.mem_valid = 0;
        #1;
        chk("t3_rd11", 64'(ifc.rf_rd), 11);
        chk("t3_cnt0", 64'(ifc.pend_cnt), 0);
        chk("t3_err",  64'(ifc.err_unexp), 0);

        // 4. Write to x0 is accepted but not performed
        ifc.mem_valid = 1; ifc.mem_rd = 0; ifc.mem_data = 32'h55;
        #1 chk("t4_mrdy", 64'(ifc.mem_ready), 1);
        cyc();
        ifc.mem_valid = 0;
        #1;
        chk("t4_we",  64'(ifc.rf_we), 0);
        chk("t4_cnt", 64'(ifc.pend_cnt), 0);
        chk("t4_err", 64'(ifc.err_unexp), 0);

        // 5. Flush drops pending bits and a same-cycle issue
        issue(0, 0, 7, 1); cyc();
        issue(0, 0, 8, 1); cyc();
        issue(0, 0, 9, 1);
        ifc.flush = 1;
        #1 chk("t5_cnt2", 64'(ifc.pend_cnt), 2);
        cyc();
        ifc.flush = 0;
        issue(9, 0, 0, 0);
        #1;
        chk("t5_cnt0",  64'(ifc.pend_cnt), 0);
        chk("t5_no9",   64'(ifc.iss_stall), 0);
        cyc();
        ifc.iss_valid = 0;
        ifc.alu_valid = 1; ifc.alu_rd = 7; ifc.alu_data = 32'h77;
        cyc();
        ifc.alu_valid = 0;
        #1;
        chk("t5_err", 64'(ifc.err_unexp), 1);
        chk("t5_we",  64'(ifc.rf_we), 1);
        chk("t5_rd",  64'(ifc.rf_rd), 7);

        // 6. Asynchronous reset in the middle of a write
        do_reset();
        cyc();
        issue(0, 0, 6, 1);  cyc();
        issue(0, 0, 12, 1); cyc();
        ifc.iss_valid = 0;
        ifc.alu_valid = 1; ifc.alu_rd = 6; ifc.alu_data = 32'h1234;
        cyc();
        #1;
        chk("t6_we1",  64'(ifc.rf_we), 1);
        chk("t6_cnt1", 64'(ifc.pend_cnt), 1);
        rst = 0;
        #1;
        chk("t6_we0",  64'(ifc.rf_we), 0);
        chk("t6_cnt0", 64'(ifc.pend_cnt), 0);
        chk("t6_rdy0", 64'(ifc.alu_ready), 0);
        cyc();
        idle();
        rst = 1;
        cyc();
        chk("t6_after", 64'(ifc.rf_we), 0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
